// File: rtl/dbg_uart_pkg.sv
// Shared types and ASCII helpers for the debug-bus UART transmitter.
// Line length and FIFO word width depend on DBG_UART_TIMESTAMP_EN.
package dbg_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DIGIT = 8'h30;
    localparam logic [7:0] ASCII_ALPHA = 8'h41;

`ifdef DBG_UART_TIMESTAMP_EN
    localparam int LINE_CHARS = 19;
    localparam int WORD_W     = 64;
`else
    localparam int LINE_CHARS = 10;
    localparam int WORD_W     = 32;
`endif

    localparam int IDX_W = 5;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_DIGIT + {4'd0, nib};
        end
        return ASCII_ALPHA + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Single-clock show-ahead FIFO: rdata_o is the head entry, consumed by pop_i.
// Pushes while full and pops while empty are ignored.
module dbg_fifo #(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == DEPTH);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// Captures changes of the CPU debug word and prints each as a hex line on an 8N1 UART.
// Define DBG_UART_TIMESTAMP_EN to prefix every line with a 32-bit capture-cycle stamp.
module dbg_uart_tx
    import dbg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         dbg_in,
    input  logic                en,
    output logic                tx,
    output logic                busy,
    output logic                overflow,
    output logic [FIFO_AW:0]    level
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LINE_CHARS - 1);

    logic [31:0]       dbg_q;
    logic              changed;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_wdata;
    logic [WORD_W-1:0] fifo_rdata;
    logic              overflow_q;
    logic              busy_q;

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        char_q, char_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_q, tx_d;

    assign changed = en && (dbg_in != dbg_q);
    assign push    = changed && !fifo_full;

`ifdef DBG_UART_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign fifo_wdata = {ts_q, dbg_in};

    function automatic logic [7:0] line_char(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] i);
        logic [WORD_W-1:0] sh;
        if (i < 5'd8) begin
            sh = w << {i, 2'b00};
            return nib_to_ascii(sh[63:60]);
        end
        if (i == 5'd8) begin
            return ASCII_SPACE;
        end
        if (i < 5'd17) begin
            sh = w << {i - 5'd9, 2'b00};
            return nib_to_ascii(sh[31:28]);
        end
        return (i == 5'd17) ? ASCII_CR : ASCII_LF;
    endfunction
`else
    assign fifo_wdata = dbg_in;

    function automatic logic [7:0] line_char(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] i);
        logic [WORD_W-1:0] sh;
        if (i < 5'd8) begin
            sh = w << {i, 2'b00};
            return nib_to_ascii(sh[31:28]);
        end
        return (i == 5'd8) ? ASCII_CR : ASCII_LF;
    endfunction
`endif

    dbg_fifo #(
        .W  (WORD_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // Full is judged on the registered level, so a same-cycle pop never rescues a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_q      <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dbg_q  <= dbg_in;
            busy_q <= (state_q != ST_IDLE) || !fifo_empty;
            if (changed && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            char_q  <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            char_q  <= char_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

    // char_q doubles as the bit shifter: bit 0 is always the next data bit on the wire.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        char_d  = char_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_rdata;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d   = '0;
                char_d  = line_char(word_q, '0);
                cnt_d   = BIT_RELOAD;
                tx_d    = 1'b0;
                state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_RELOAD;
                    bit_d   = '0;
                    tx_d    = char_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        char_d = {1'b0, char_q[7:1]};
                        tx_d   = char_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        char_d  = line_char(word_q, idx_q + 1'b1);
                        cnt_d   = BIT_RELOAD;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
